// File: rtl/fifo_bus_sel_arbiter.sv
// fifo_bus_sel_arbiter: round-robin packet arbiter for one output FIFO of the bus-select crosspoint
module fifo_bus_sel_arbiter #(
  parameter int PORT_NUM = 16,
  parameter int IDX_W    = 4,
  parameter int MAX_HOLD = 2048,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PORT_NUM-1:0] fifo_bus_sel,
  input  logic                fifo_full,
  output logic [PORT_NUM-1:0] grant,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                grant_valid,
  output logic                timeout_err,
  output logic [CNT_W-1:0]    pkt_cnt
);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
  state_t           state;
  logic [IDX_W-1:0] rr_ptr, win, cand;
  logic [HOLD_W-1:0] hold_cnt;
  logic             req_any;
  // Descending scan so the last hit is the first requester at or after rr_ptr.
  always_comb begin
    win = '0;
    cand = '0;
    req_any = 1'b0;
    for (int i = PORT_NUM - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(rr_ptr) + i) % PORT_NUM);
      if (fifo_bus_sel[cand]) begin
        win = cand;
        req_any = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      grant_idx <= '0;
      grant_valid <= 1'b0;
      timeout_err <= 1'b0;
      pkt_cnt <= '0;
      rr_ptr <= '0;
      hold_cnt <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: if (req_any && !fifo_full) begin
          grant <= PORT_NUM'(1) << win;
          grant_idx <= win;
          grant_valid <= 1'b1;
          rr_ptr <= (win == IDX_W'(PORT_NUM - 1)) ? '0 : win + IDX_W'(1);
          pkt_cnt <= pkt_cnt + CNT_W'(1);
          hold_cnt <= '0;
          state <= BUSY;
        end
        BUSY: begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
          // A dropped request wins over the hold limit, so timeout only flags a still-held request.
          if (!fifo_bus_sel[grant_idx] || hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
            grant <= '0;
            grant_valid <= 1'b0;
            timeout_err <= fifo_bus_sel[grant_idx];
            state <= GAP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_bus_sel_arbiter.sv
// tb_fifo_bus_sel_arbiter: directed scenarios plus randomized traffic against a packet-level model
module tb_fifo_bus_sel_arbiter;
  localparam int MH = 8;
  logic        clk = 1'b0, rst = 1'b1, full = 1'b0;
  logic [15:0] sel = '0;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_valid, timeout_err;
  logic [15:0] pkt_cnt;
  int n_cmp = 0, n_err = 0;
  int m_owner = -1, m_age = 0, m_ptr = 0, m_last = 0, m_cnt = 0;
  bit m_gap = 0, m_to = 0;

  fifo_bus_sel_arbiter #(.PORT_NUM(16), .IDX_W(4), .MAX_HOLD(MH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .fifo_bus_sel(sel), .fifo_full(full), .grant(grant),
    .grant_idx(grant_idx), .grant_valid(grant_valid), .timeout_err(timeout_err), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  // Model: a packet owner ages by one per cycle it is granted; release on drop or at MH cycles, then one dead cycle.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_owner = -1; m_gap = 0; m_ptr = 0; m_last = 0; m_cnt = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (m_gap) m_gap = 0;
      else if (m_owner >= 0) begin
        if (!sel[m_owner]) begin m_owner = -1; m_gap = 1; end
        else if (m_age == MH) begin m_owner = -1; m_gap = 1; m_to = 1; end
        else m_age++;
      end else if (sel != 0 && !full) begin
        for (int k = 0; k < 16; k++) if (m_owner < 0 && sel[(m_ptr + k) % 16]) m_owner = (m_ptr + k) % 16;
        m_last = m_owner; m_ptr = (m_owner + 1) % 16; m_cnt = (m_cnt + 1) % 65536; m_age = 1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; sel = '0; full = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (grant !== 16'h0) begin n_err++; $display("FAIL reset_grant got %h want 0000", grant); end
    n_cmp++; if (grant_idx !== 4'd0) begin n_err++; $display("FAIL reset_idx got %0d want 0", grant_idx); end
    n_cmp++; if (grant_valid !== 1'b0 || timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_flags got v=%b t=%b want 0 0", grant_valid, timeout_err); end
    n_cmp++; if (pkt_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", pkt_cnt); end
  endtask

  task automatic test_basic();
    do_reset();
    sel = 16'h0004;
    tick();
    n_cmp++; if (grant !== 16'h0004) begin n_err++; $display("FAIL basic_grant got %h want 0004", grant); end
    n_cmp++; if (grant_idx !== 4'd2 || grant_valid !== 1'b1) begin n_err++; $display("FAIL basic_idx got idx=%0d v=%b want 2 1", grant_idx, grant_valid); end
    n_cmp++; if (pkt_cnt !== 16'd1) begin n_err++; $display("FAIL basic_cnt got %0d want 1", pkt_cnt); end
    sel = 16'h0;
    tick();
    n_cmp++; if (grant !== 16'h0 || grant_valid !== 1'b0) begin n_err++; $display("FAIL basic_release got %h v=%b want 0000 0", grant, grant_valid); end
    n_cmp++; if (grant_idx !== 4'd2) begin n_err++; $display("FAIL basic_idx_keep got %0d want 2", grant_idx); end
    tick();
    n_cmp++; if (grant !== 16'h0) begin n_err++; $display("FAIL basic_idle got %h want 0000", grant); end
  endtask

  task automatic test_round_robin();
    int exp_w[4] = '{0, 4, 0, 4};
    do_reset();
    sel = 16'h0011;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if (grant !== 16'(1 << exp_w[k]) || grant_idx !== 4'(exp_w[k])) begin n_err++; $display("FAIL rr_win%0d got %h idx=%0d want port %0d", k, grant, grant_idx, exp_w[k]); end
      sel = 16'h0011 & ~16'(1 << exp_w[k]);
      tick();
      n_cmp++; if (grant !== 16'h0) begin n_err++; $display("FAIL rr_release%0d got %h want 0000", k, grant); end
      sel = 16'h0011;
      tick();
      n_cmp++; if (grant !== 16'h0) begin n_err++; $display("FAIL rr_gap%0d got %h want 0000", k, grant); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    sel = 16'h8000;
    tick();
    n_cmp++; if (grant !== 16'h8000 || grant_idx !== 4'd15) begin n_err++; $display("FAIL wrap_15 got %h idx=%0d want 8000 15", grant, grant_idx); end
    sel = 16'h0;
    tick(); tick();
    sel = 16'h8001;
    tick();
    n_cmp++; if (grant !== 16'h0001 || grant_idx !== 4'd0) begin n_err++; $display("FAIL wrap_0 got %h idx=%0d want 0001 0", grant, grant_idx); end
  endtask

  task automatic test_full();
    do_reset();
    full = 1'b1; sel = 16'h0100;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++; if (grant !== 16'h0) begin n_err++; $display("FAIL full_block%0d got %h want 0000", c, grant); end
    end
    full = 1'b0;
    tick();
    n_cmp++; if (grant !== 16'h0100) begin n_err++; $display("FAIL full_release got %h want 0100", grant); end
    full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (grant !== 16'h0100) begin n_err++; $display("FAIL full_hold%0d got %h want 0100", c, grant); end
    end
    full = 1'b0; sel = 16'h0;
    tick();
    n_cmp++; if (grant !== 16'h0) begin n_err++; $display("FAIL full_drop got %h want 0000", grant); end
  endtask

  task automatic test_timeout();
    do_reset();
    sel = 16'h0002;
    tick();
    for (int c = 1; c < MH; c++) begin
      n_cmp++; if (grant !== 16'h0002 || timeout_err !== 1'b0) begin n_err++; $display("FAIL to_hold%0d got %h t=%b want 0002 0", c, grant, timeout_err); end
      tick();
    end
    n_cmp++; if (grant !== 16'h0002) begin n_err++; $display("FAIL to_last got %h want 0002", grant); end
    tick();
    n_cmp++; if (grant !== 16'h0 || timeout_err !== 1'b1) begin n_err++; $display("FAIL to_pulse got %h t=%b want 0000 1", grant, timeout_err); end
    tick();
    n_cmp++; if (grant !== 16'h0 || timeout_err !== 1'b0) begin n_err++; $display("FAIL to_gap got %h t=%b want 0000 0", grant, timeout_err); end
    tick();
    n_cmp++; if (grant !== 16'h0002 || pkt_cnt !== 16'd2) begin n_err++; $display("FAIL to_regrant got %h cnt=%0d want 0002 2", grant, pkt_cnt); end
    sel = 16'h0;
  endtask

  task automatic test_async_reset();
    do_reset();
    sel = 16'h0040;
    tick();
    n_cmp++; if (grant !== 16'h0040 || pkt_cnt !== 16'd1) begin n_err++; $display("FAIL ar_busy got %h cnt=%0d want 0040 1", grant, pkt_cnt); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (grant !== 16'h0 || grant_valid !== 1'b0 || pkt_cnt !== 16'd0) begin n_err++; $display("FAIL ar_clear got %h v=%b cnt=%0d want 0000 0 0", grant, grant_valid, pkt_cnt); end
    tick();
    rst = 1'b0; sel = 16'h0041;
    tick();
    n_cmp++; if (grant !== 16'h0001 || grant_idx !== 4'd0) begin n_err++; $display("FAIL ar_winner got %h idx=%0d want 0001 0", grant, grant_idx); end
  endtask

  task automatic test_random();
    logic [15:0] exp_g;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      sel = sel ^ 16'($urandom & $urandom & $urandom);
      full = ($urandom_range(0, 3) == 0);
      tick();
      exp_g = (m_owner >= 0) ? 16'(1 << m_owner) : 16'h0;
      n_cmp++; if (grant !== exp_g) begin n_err++; $display("FAIL rnd_grant c=%0d got %h want %h", c, grant, exp_g); end
      n_cmp++; if (grant_idx !== 4'(m_last) || grant_valid !== (m_owner >= 0)) begin n_err++; $display("FAIL rnd_idx c=%0d got idx=%0d v=%b want %0d %b", c, grant_idx, grant_valid, m_last, m_owner >= 0); end
      n_cmp++; if (timeout_err !== m_to || pkt_cnt !== 16'(m_cnt)) begin n_err++; $display("FAIL rnd_to_cnt c=%0d got t=%b cnt=%0d want %b %0d", c, timeout_err, pkt_cnt, m_to, m_cnt); end
      n_cmp++; if ((grant & (grant - 16'h1)) !== 16'h0 || grant_valid !== |grant) begin n_err++; $display("FAIL rnd_onehot c=%0d got %h v=%b want onehot/zero", c, grant, grant_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_wrap();
    test_full();
    test_timeout();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_bus_sel_arbiter.md
Name: fifo_bus_sel_arbiter

Overview:
- Sits on the output-FIFO side of the 16x16 bus-select crosspoint, one instance per output FIFO.
- Input: the transposed request vector for its FIFO (bit x set = forwarding decision x wants this FIFO).
- Picks one requesting input port round-robin, returns a registered one-hot grant and holds it for the whole packet.
- Throttles new grants on FIFO full and enforces a maximum hold time.

Parameters:
PORT_NUM, 16, number of input ports = request/grant vector width
IDX_W, 4, width of grant_idx; must satisfy 2**IDX_W >= PORT_NUM
MAX_HOLD, 2048, maximum cycles a single grant may stay asserted before forced release
CNT_W, 16, width of pkt_cnt

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
fifo_bus_sel  input  PORT_NUM  request vector; bit x = input x requests this FIFO; requester holds bit high until end of packet
fifo_full  input  1  FIFO cannot accept a new packet; blocks new grants only
grant  output  PORT_NUM  registered one-hot grant back toward the fd side; all-zero when idle
grant_idx  output  IDX_W  binary index of the current/last winner
grant_valid  output  1  high while grant is non-zero
timeout_err  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD
pkt_cnt  output  CNT_W  count of grants issued; wraps to 0

Behaviour:
- Reset (async, rst=1): grant=0, grant_idx=0, grant_valid=0, timeout_err=0, pkt_cnt=0, rr_ptr=0, hold_cnt=0, state=IDLE.
- States: IDLE, BUSY, GAP. All outputs are registered.
- IDLE:
  - If fifo_bus_sel!=0 and fifo_full=0: winner = first set bit scanning rr_ptr, rr_ptr+1, ..., PORT_NUM-1, 0, ..., rr_ptr-1.
  - Next edge: grant=1<<winner, grant_idx=winner, grant_valid=1, rr_ptr=(winner+1) mod PORT_NUM, pkt_cnt+=1, hold_cnt=0, go BUSY.
  - Latency: request sampled at edge n, grant visible after edge n+1 (one cycle).
  - If fifo_full=1 or no request: stay IDLE, grant stays 0.
- BUSY:
  - hold_cnt increments each cycle.
  - If fifo_bus_sel[grant_idx]=0: next edge grant=0, grant_valid=0, go GAP.
  - Else if hold_cnt==MAX_HOLD-1: next edge grant=0, grant_valid=0, timeout_err=1 for exactly one cycle, go GAP.
  - Else hold grant.
  - fifo_full and other request bits are ignored in BUSY; a packet is never cut by fifo_full.
- GAP:
  - Exactly one cycle, grant=0, then IDLE.
  - Guarantees at least one dead cycle between consecutive grants, including re-grant to the same port.
- grant_idx retains the last winner after release; only grant/grant_valid clear.
- rr_ptr wraps: winner PORT_NUM-1 gives rr_ptr=0.
- pkt_cnt wraps from 2**CNT_W-1 to 0. A timeout does not decrement it.
- Simultaneous events in BUSY: request drop and hold limit in the same cycle → treated as normal release, no timeout_err.
- Request bit for a port already granted that drops and rises in one cycle is not detectable; the requester must hold it low for at least one cycle between packets.
- Reset asserted mid-BUSY: grant clears immediately (asynchronously); after release the arbiter starts in IDLE with rr_ptr=0.
- Invariant: grant is always zero or one-hot, and grant_valid == |grant.

Test Plan:
- Reset, then fifo_bus_sel=0x0004 → one cycle later grant=0x0004, grant_idx=2, grant_valid=1, pkt_cnt=1. Drop request → grant=0 next cycle, one GAP cycle, back to IDLE.
- Round-robin: after reset, held fifo_bus_sel=0x0011, each packet released by dropping its bit for one cycle → winners 0, 4, 0, 4; a GAP cycle with grant=0 between each.
- Wrap: win port 15 (req 0x8000), release, then req 0x8001 → next winner 0 (rr_ptr wrapped), grant=0x0001.
- fifo_full=1 with req 0x0100 → grant stays 0 for 10 cycles. Deassert fifo_full → grant=0x0100 one cycle later. Assert fifo_full during BUSY → grant held.
- MAX_HOLD=8, req 0x0002 held forever → grant high exactly 8 cycles, then grant=0 and timeout_err pulses for 1 cycle. Re-grant to port 1 after GAP, pkt_cnt=2.
- Assert rst mid-BUSY with grant=0x0040 → grant=0, pkt_cnt=0 without a clock edge. After release with req 0x0041 → winner 0.
